// File: rtl/csa_accum_sequencer.sv
// Multi-beat carry-save accumulator: keeps the packet total in redundant sum/carry form
// and resolves it with one carry-propagate add per packet before a valid/ready output.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// state   | meaning
// ACCUM   | accepting beats, folding operands into acc_s/acc_c
// RESOLVE | one cycle: carry-propagate add, latch result, clear accumulator
// OUT     | result presented, waiting for out_ready
module csa_accum_sequencer #(
  parameter int N     = 9,
  parameter int W     = 4,
  parameter int MAXB  = 16,
  parameter int ACC_W = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*W-1:0]          in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_sum,
  output logic                    out_trunc,
  output logic [$clog2(MAXB):0]   out_beats
);
  localparam int BW = $clog2(MAXB) + 1;

  typedef enum logic [1:0] {ACCUM, RESOLVE, OUT} state_t;

  state_t             state, state_nx;
  logic [ACC_W-1:0]   acc_s, acc_c;
  logic [ACC_W-1:0]   tree_s, tree_c;
  logic [BW-1:0]      beat_cnt, beat_inc;
  logic               trunc_pend;
  logic               run;
  logic               at_max;
  logic               take;

  // Linear chain of 3:2 compressor rows: each row folds one operand into (sum, carry).
  for (genvar k = 0; k < N; k++) begin : g_stage
    logic [ACC_W-1:0] s_in, c_in, op, s_out, c_out;
    logic [ACC_W-2:0] co;
    if (k == 0) begin : g_first
      assign s_in = acc_s;
      assign c_in = acc_c;
    end else begin : g_next
      assign s_in = g_stage[k-1].s_out;
      assign c_in = g_stage[k-1].c_out;
    end
    assign op = {{(ACC_W-W){1'b0}}, in_data[k*W +: W]};
    for (genvar b = 0; b < ACC_W; b++) begin : g_bit
      if (b < ACC_W - 1) begin : g_fa
        full_adder u_fa (.a(s_in[b]), .b(c_in[b]), .ci(op[b]), .s(s_out[b]), .co(co[b]));
      end else begin : g_fa_msb
        logic unused_co;
        full_adder u_fa (.a(s_in[b]), .b(c_in[b]), .ci(op[b]), .s(s_out[b]), .co(unused_co));
      end
    end
    assign c_out = {co, 1'b0};
  end

  assign tree_s   = g_stage[N-1].s_out;
  assign tree_c   = g_stage[N-1].c_out;
  assign beat_inc = beat_cnt + 1'b1;
  assign at_max   = (beat_inc == BW'(MAXB));
  assign take     = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ACCUM: begin
        in_ready = run;
        if (run && in_valid && (in_last || at_max)) state_nx = RESOLVE;
      end
      RESOLVE: state_nx = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = ACCUM;
      end
      default: state_nx = ACCUM;
    endcase
  end

  // run holds in_ready low for the first cycle out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run        <= 1'b0;
      acc_s      <= '0;
      acc_c      <= '0;
      beat_cnt   <= '0;
      trunc_pend <= 1'b0;
      out_sum    <= '0;
      out_trunc  <= 1'b0;
      out_beats  <= '0;
    end else begin
      run <= 1'b1;
      unique case (state)
        ACCUM: begin
          if (take) begin
            acc_s      <= tree_s;
            acc_c      <= tree_c;
            beat_cnt   <= beat_inc;
            trunc_pend <= at_max & ~in_last;
          end
        end
        RESOLVE: begin
          out_sum    <= acc_s + acc_c;
          out_beats  <= beat_cnt;
          out_trunc  <= trunc_pend;
          acc_s      <= '0;
          acc_c      <= '0;
          beat_cnt   <= '0;
          trunc_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
